// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared types and constants for the instruction-memory boot loader.
//   - state_t        : loader FSM states (CHK is only entered when the
//                      IMEM_LOADER_CHECKSUM_EN macro is defined)
//   - BYTES_PER_WORD : bytes packed into one instruction word
//   - WORD_SHIFT     : word index to byte address shift
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR,
    DATA,
    CHK,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_SHIFT     = 2;

endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer
//   Packs an accepted byte stream little-endian into 32-bit words.
//   The first byte of a word ends up in [7:0], the fourth in [31:24].
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset
//     clear        : synchronous clear of byte counter, shift register and pulse
//     byte_valid   : a byte is transferred this cycle
//     byte_in      : the transferred byte
//     word_done    : combinational, high when this transfer completes a word
//     word_valid   : registered one-cycle pulse the cycle after word_done
//     word         : assembled word, valid while word_valid is high
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic        word_done,
  output logic        word_valid,
  output logic [31:0] word
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  byte_cnt_reg;
  logic [31:0] shift_reg;
  logic        word_valid_reg;

  assign word_done  = byte_valid && (byte_cnt_reg == LAST_LANE);
  assign word_valid = word_valid_reg;
  // After four right-shifts the first byte sits in the low lane, so the
  // shift register itself is the finished word during the write pulse.
  assign word       = shift_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_reg   <= '0;
      shift_reg      <= '0;
      word_valid_reg <= 1'b0;
    end else if (clear) begin
      byte_cnt_reg   <= '0;
      shift_reg      <= '0;
      word_valid_reg <= 1'b0;
    end else begin
      word_valid_reg <= word_done;
      if (byte_valid) begin
        byte_cnt_reg <= byte_cnt_reg + 2'd1;  // wraps 3 -> 0
        shift_reg    <= {byte_in, shift_reg[31:8]};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time writer for the instruction memory. Receives a framed byte
//   stream (header byte N = word count, then 4*N data bytes, optionally a
//   trailing XOR checksum byte), packs it into words and writes them to the
//   instruction memory while holding the CPU stalled.
//   Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
//   checksum byte equal to the XOR of all data bytes.
//   Ports:
//     clk, rst_n          : clock, asynchronous active-low reset
//     Rx_Data/Valid/Ready : byte stream handshake
//     Restart             : synchronous pulse, return to header wait
//     Wr_En/Addr/Data     : instruction memory write port
//     Cpu_Stall           : holds CPU fetch until an image is loaded
//     Load_Done, Load_Err : load status
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        Rx_Data,
  input  logic              Rx_Valid,
  output logic              Rx_Ready,
  input  logic              Restart,
  output logic              Wr_En,
  output logic [ADDR_W-1:0] Wr_Addr,
  output logic [31:0]       Wr_Data,
  output logic              Cpu_Stall,
  output logic              Load_Done,
  output logic              Load_Err
);

  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  state_t     state_reg;
  logic [7:0] n_words_reg;
  logic [7:0] word_cnt_reg;
  logic       cpu_stall_reg;
  logic       load_done_reg;
  logic       load_err_reg;
  logic       accept;
  logic       word_done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_reg;
`endif

  // Ready depends only on registered state plus Restart, which blocks any
  // handshake in the cycle it is asserted.
  assign Rx_Ready  = ((state_reg == HDR) || (state_reg == DATA) || (state_reg == CHK)) && !Restart;
  assign accept    = Rx_Valid && Rx_Ready;
  assign Cpu_Stall = cpu_stall_reg;
  assign Load_Done = load_done_reg;
  assign Load_Err  = load_err_reg;

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (Restart || (state_reg == HDR)),
    .byte_valid (accept && (state_reg == DATA)),
    .byte_in    (Rx_Data),
    .word_done  (word_done),
    .word_valid (Wr_En),
    .word       (Wr_Data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= HDR;
      n_words_reg   <= '0;
      word_cnt_reg  <= '0;
      Wr_Addr       <= '0;
      cpu_stall_reg <= 1'b1;
      load_done_reg <= 1'b0;
      load_err_reg  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_reg       <= '0;
`endif
    end else if (Restart) begin
      state_reg     <= HDR;
      n_words_reg   <= '0;
      word_cnt_reg  <= '0;
      cpu_stall_reg <= 1'b1;
      load_done_reg <= 1'b0;
      load_err_reg  <= 1'b0;
    end else begin
      case (state_reg)
        HDR: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_reg <= '0;
`endif
          if (accept) begin
            if ((Rx_Data == 8'd0) || (Rx_Data > DEPTH_B)) begin
              state_reg    <= ERR;
              load_err_reg <= 1'b1;
            end else begin
              n_words_reg  <= Rx_Data;
              word_cnt_reg <= '0;
              state_reg    <= DATA;
            end
          end
        end
        DATA: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          if (accept) xor_reg <= xor_reg ^ Rx_Data;
`endif
          if (word_done) begin
            // Address is registered alongside the packer's write pulse.
            Wr_Addr      <= ADDR_W'(word_cnt_reg) << WORD_SHIFT;
            word_cnt_reg <= word_cnt_reg + 8'd1;
            if (word_cnt_reg == n_words_reg - 8'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_reg     <= CHK;
`else
              state_reg     <= DONE;
              load_done_reg <= 1'b1;
              cpu_stall_reg <= 1'b0;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            if (Rx_Data == xor_reg) begin
              state_reg     <= DONE;
              load_done_reg <= 1'b1;
              cpu_stall_reg <= 1'b0;
            end else begin
              state_reg    <= ERR;
              load_err_reg <= 1'b1;
            end
          end
        end
`endif
        DONE: state_reg <= DONE;
        ERR:  state_reg <= ERR;
        default: state_reg <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Randomized self-checking bench for imem_loader. Images are described as
//   a header plus a byte queue; expected writes and final status come from a
//   simple arithmetic model of the framing rules. Compile with
//   +define+IMEM_LOADER_CHECKSUM_EN to exercise the checksum variant.
module tb_imem_loader;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 32;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        Rx_Data;
  logic              Rx_Valid;
  logic              Rx_Ready;
  logic              Restart;
  logic              Wr_En;
  logic [ADDR_W-1:0] Wr_Addr;
  logic [31:0]       Wr_Data;
  logic              Cpu_Stall;
  logic              Load_Done;
  logic              Load_Err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        done;
    logic        stall;
  } wr_t;

  wr_t        wr_q[$];
  logic [7:0] img[$];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Rx_Data   (Rx_Data),
    .Rx_Valid  (Rx_Valid),
    .Rx_Ready  (Rx_Ready),
    .Restart   (Restart),
    .Wr_En     (Wr_En),
    .Wr_Addr   (Wr_Addr),
    .Wr_Data   (Wr_Data),
    .Cpu_Stall (Cpu_Stall),
    .Load_Done (Load_Done),
    .Load_Err  (Load_Err)
  );

  always #5 clk = ~clk;

  // Write monitor: records every strobe with the status flags seen alongside.
  always @(negedge clk) begin : mon
    wr_t e;
    if (rst_n && Wr_En) begin
      e.addr  = Wr_Addr;
      e.data  = Wr_Data;
      e.done  = Load_Done;
      e.stall = Cpu_Stall;
      wr_q.push_back(e);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int gap_for(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 3));
  endfunction

  // Called at a negedge; returns at a negedge with Rx_Valid low.
  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    ok = 1'b0;
    repeat (gap) @(negedge clk);
    Rx_Data  = b;
    Rx_Valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      #1;
      if (Rx_Ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    Rx_Valid = 1'b0;
  endtask

  task automatic pulse_restart();
    Restart = 1'b1;
    @(negedge clk);
    Restart = 1'b0;
  endtask

  // Loads img as an image with header hdr and checks writes and status.
  task automatic run_image(input string name, input int hdr, input bit corrupt,
                           input int gap_mode, input bit pre_restart);
    bit          ok;
    bit          bad_hdr;
    bit          exp_done;
    int          n_exp;
    logic [7:0]  x;
    logic [31:0] w;
    if (pre_restart) pulse_restart();
    wr_q.delete();
    send_byte(hdr[7:0], 0, ok);
    check_eq({name, "/hdr_hs"}, 32'(ok), 32'd1);
    bad_hdr = (hdr == 0) || (hdr > DEPTH);
    if (!bad_hdr) begin
      x = 8'h00;
      for (int i = 0; i < 4 * hdr; i++) begin
        x = x ^ img[i];
        send_byte(img[i], gap_for(gap_mode), ok);
        if (!ok) begin
          check_eq({name, "/data_hs"}, 32'(ok), 32'd1);
          break;
        end
      end
      if (CHK_EN) begin
        send_byte(corrupt ? (x ^ 8'h01) : x, gap_for(gap_mode), ok);
        check_eq({name, "/chk_hs"}, 32'(ok), 32'd1);
      end
    end
    repeat (3) @(negedge clk);
    n_exp    = bad_hdr ? 0 : hdr;
    exp_done = !bad_hdr && !(CHK_EN && corrupt);
    check_eq({name, "/wcount"}, 32'(wr_q.size()), 32'(n_exp));
    for (int i = 0; i < n_exp && i < wr_q.size(); i++) begin
      w = 32'(img[4*i]) + (32'(img[4*i+1]) << 8) + (32'(img[4*i+2]) << 16) + (32'(img[4*i+3]) << 24);
      check_eq($sformatf("%s/addr%0d", name, i), wr_q[i].addr, 32'(i * 4));
      check_eq($sformatf("%s/data%0d", name, i), wr_q[i].data, w);
    end
    if (n_exp > 0 && wr_q.size() == n_exp) begin
      check_eq({name, "/done_at_last_wr"}, 32'(wr_q[n_exp-1].done), 32'(!CHK_EN));
      check_eq({name, "/stall_at_last_wr"}, 32'(wr_q[n_exp-1].stall), 32'(CHK_EN));
    end
    check_eq({name, "/load_done"}, 32'(Load_Done), 32'(exp_done));
    check_eq({name, "/load_err"}, 32'(Load_Err), 32'(!exp_done));
    check_eq({name, "/cpu_stall"}, 32'(Cpu_Stall), 32'(!exp_done));
    check_eq({name, "/rx_ready"}, 32'(Rx_Ready), 32'd0);
    $display("[TB] %s: hdr=%0d writes=%0d done=%0b err=%0b", name, hdr, wr_q.size(), Load_Done, Load_Err);
  endtask

  task automatic fill_random(input int nbytes);
    img.delete();
    for (int i = 0; i < nbytes; i++) img.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    bit ok;
    int hdr;
    rst_n    = 1'b0;
    Rx_Data  = 8'h00;
    Rx_Valid = 1'b0;
    Restart  = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst/cpu_stall", 32'(Cpu_Stall), 32'd1);
    check_eq("rst/load_done", 32'(Load_Done), 32'd0);
    check_eq("rst/load_err", 32'(Load_Err), 32'd0);
    check_eq("rst/wr_en", 32'(Wr_En), 32'd0);
    check_eq("rst/wr_addr", Wr_Addr, 32'd0);
    check_eq("rst/wr_data", Wr_Data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst/rx_ready", 32'(Rx_Ready), 32'd1);

    // Two-word image with random gaps.
    img = '{8'hB7, 8'h50, 8'h34, 8'h12, 8'h17, 8'h51, 8'h34, 8'h12};
    run_image("two_words", 2, 1'b0, 2, 1'b0);
    if (wr_q.size() > 1) check_eq("two_words/const1", wr_q[1].data, 32'h12345117);
    if (CHK_EN) run_image("two_words_badchk", 2, 1'b1, 0, 1'b1);

    // Illegal headers.
    run_image("hdr_zero", 0, 1'b0, 0, 1'b1);
    run_image("hdr_over", 33, 1'b0, 0, 1'b1);

    // Rx_Valid toggling every other cycle.
    img = '{8'h13, 8'h01, 8'hA0, 8'h00};
    run_image("toggle", 1, 1'b0, 1, 1'b1);

    // Restart coincident with a valid byte mid-word.
    fill_random(8);
    pulse_restart();
    wr_q.delete();
    send_byte(8'd2, 0, ok);
    for (int i = 0; i < 6; i++) send_byte(img[i], 0, ok);
    Rx_Data  = 8'hEE;
    Rx_Valid = 1'b1;
    Restart  = 1'b1;
    #1;
    check_eq("restart/ready_blocked", 32'(Rx_Ready), 32'd0);
    @(negedge clk);
    Restart  = 1'b0;
    Rx_Valid = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("restart/wcount", 32'(wr_q.size()), 32'd1);
    check_eq("restart/cpu_stall", 32'(Cpu_Stall), 32'd1);
    check_eq("restart/load_done", 32'(Load_Done), 32'd0);
    check_eq("restart/rx_ready", 32'(Rx_Ready), 32'd1);
    $display("[TB] restart: writes=%0d stall=%0b", wr_q.size(), Cpu_Stall);
    fill_random(4);
    run_image("after_restart", 1, 1'b0, 0, 1'b0);

    // Asynchronous reset mid-word.
    fill_random(4);
    pulse_restart();
    wr_q.delete();
    send_byte(8'd1, 0, ok);
    for (int i = 0; i < 3; i++) send_byte(img[i], 0, ok);
    rst_n = 1'b0;
    #1;
    check_eq("midrst/cpu_stall", 32'(Cpu_Stall), 32'd1);
    check_eq("midrst/wr_data", Wr_Data, 32'd0);
    check_eq("midrst/wr_en", 32'(Wr_En), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("midrst/wcount", 32'(wr_q.size()), 32'd0);
    check_eq("midrst/rx_ready", 32'(Rx_Ready), 32'd1);
    $display("[TB] mid_reset: writes=%0d", wr_q.size());
    fill_random(4);
    run_image("after_reset", 1, 1'b0, 0, 1'b0);

    // Full-depth image of counting data.
    img.delete();
    for (int i = 0; i < 4 * DEPTH; i++) img.push_back(8'(i));
    run_image("full", DEPTH, 1'b0, 0, 1'b1);

    // Random images, occasionally with illegal headers or bad checksums.
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 5) == 0) hdr = ($urandom_range(0, 1) == 0) ? 0 : DEPTH + int'($urandom_range(1, 3));
      else hdr = int'($urandom_range(1, DEPTH));
      fill_random(4 * DEPTH);
      run_image($sformatf("rand%0d", k), hdr, 1'($urandom_range(0, 1)), 2, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Boot-time writer for the instruction memory. It is the write-side counterpart to the CPU fetch path, which only reads.
- Accepts a framed byte stream over a valid/ready handshake. Bytes come from a UART receiver or a testbench.
- Packs bytes little-endian into 32-bit words and issues word writes to the instruction memory write port.
- Holds the CPU stalled until a complete, valid image has loaded.

Parameters:
- DEPTH, 32, number of 32-bit instruction words in the target memory (max 255).
- ADDR_W, 32, width of the write byte address (matches the fetch Addr width).

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- Rx_Data  input  8  incoming stream byte.
- Rx_Valid  input  1  Rx_Data holds a valid byte.
- Rx_Ready  output  1  loader can take a byte; a byte transfers when Rx_Valid && Rx_Ready at a rising edge.
- Restart  input  1  synchronous pulse: abort or finish the current load and wait for a new header.
- Wr_En  output  1  one-cycle write strobe to the instruction memory.
- Wr_Addr  output  ADDR_W  byte address of the write, always word aligned: word_index<<2.
- Wr_Data  output  32  assembled instruction word.
- Cpu_Stall  output  1  high holds the CPU PC/fetch.
- Load_Done  output  1  image loaded successfully.
- Load_Err  output  1  framing or checksum error.

Behaviour:
- Reset values (asynchronous on rst_n low):
  - state = HDR, word counter = 0, byte counter = 0, shift register = 0.
  - Wr_En = 0, Wr_Addr = 0, Wr_Data = 0.
  - Cpu_Stall = 1, Load_Done = 0, Load_Err = 0.
- States: HDR, DATA, CHK (only with the optional feature), DONE, ERR.
- Rx_Ready = (state==HDR || state==DATA || state==CHK) && !Restart. It is decoded from registered state only.
- HDR:
  - The accepted byte N is the word count.
  - N==0 or N>DEPTH → ERR.
  - Otherwise latch N, clear the counters, → DATA.
- DATA:
  - Each accepted byte goes into lane byte_cnt: byte 0 → [7:0], byte 3 → [31:24].
  - byte_cnt wraps 3→0.
  - On acceptance of byte 3, the next cycle drives Wr_En=1 for exactly one cycle, with:
    - Wr_Data = assembled word;
    - Wr_Addr = word_cnt<<2.
  - word_cnt increments at the same time.
  - Write latency is 1 cycle after the 4th byte handshake.
  - After word N-1 is accepted → DONE, or → CHK when CHECKSUM_EN is defined.
- Rx_Valid gaps are legal at any byte boundary. The assembler holds its state while Rx_Valid is low.
- DONE:
  - Cpu_Stall=0 and Load_Done=1, both registered, asserted in the same cycle as the final Wr_En.
  - Rx_Ready=0; further bytes are left un-accepted.
- ERR:
  - Load_Err=1, Cpu_Stall=1, Rx_Ready=0.
  - Memory contents already written are not rolled back.
- Restart:
  - Has priority over any byte handshake in the same cycle; that byte is not accepted.
  - From any state → HDR next cycle. Clears the counters, Load_Done, and Load_Err.
  - Sets Cpu_Stall=1.
  - A partial word is discarded with no write.
  - A Wr_En already scheduled for that cycle still completes.
- Reset mid-load: immediate return to reset values; no write strobe is generated.
- Wr_Addr never exceeds (DEPTH-1)<<2.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last data byte the FSM enters CHK and accepts one byte.
  - If that byte equals the XOR of all 4N data bytes → DONE; otherwise → ERR.
  - The running XOR register clears in HDR.
- Undefined: no CHK state and no XOR register; DATA goes directly to DONE.

Decomposition:
- Package imem_loader_pkg: state enum (HDR, DATA, CHK, DONE, ERR), BYTES_PER_WORD=4, WORD_SHIFT=2.
- Sub-module imem_byte_packer:
  - Owns byte_cnt, the 32-bit little-endian shift register, and the word_valid pulse.
  - Has a clear input driven by Restart/HDR.
  - The top level owns the FSM, word counter, write port, and status flags.

Test Plan:
- Header 0x02, bytes B7 50 34 12 17 51 34 12 → Wr_En twice: Addr 0x0/Data 0x123450B7, then Addr 0x4/Data 0x12345117. Load_Done=1 and Cpu_Stall=0 in the same cycle as the second Wr_En.
- Header 0x00, and separately header 0x21 with DEPTH=32 → Load_Err=1, no Wr_En, Rx_Ready=0, Cpu_Stall stays 1.
- Header 0x01, bytes 13 01 A0 00 with Rx_Valid toggling every other cycle → single write Addr 0x0, Data 0x00A00113.
- Header 0x02, 6 data bytes, then a Restart pulse coincident with a valid byte → that byte not accepted, no second write, state HDR, Cpu_Stall=1.
- DEPTH=32 full image: 32 words of counting data → last write Addr 0x7C, then Load_Done.
- With IMEM_LOADER_CHECKSUM_EN: the first scenario followed by the correct XOR byte → Load_Done. The same image with the checksum byte XOR 0x01 → Load_Err.
